// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the RV32I load/store unit:
//   - access-size encodings (RV32I funct3 values)
//   - FSM state type
//   - request legality check and word-address helper
// -----------------------------------------------------------------------------
package lsu_pkg;

  // Access sizes, encoded exactly as the RV32I funct3 field.
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    RMW_WRITE = 2'd2
  } lsu_state_t;

  // A request is legal when the size code exists, the address is naturally
  // aligned for that size, and unsigned sizes are only used by loads.
  function automatic logic req_legal(input logic       we,
                                     input logic [2:0] size,
                                     input logic [1:0] off);
    logic ok;
    case (size)
      LDST_B:  ok = 1'b1;
      LDST_BU: ok = !we;
      LDST_H:  ok = !off[0];
      LDST_HU: ok = !we && !off[0];
      LDST_W:  ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // The data memory is word-organised; the low two address bits never leave
  // the LSU.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
// Purely combinational byte-lane steering shared by the load and RMW paths.
//   rdata_i  word returned by the data memory
//   off_i    byte offset within the word (addr[1:0])
//   size_i   access size (funct3 encoding)
//   wd_i     store data, LSB-aligned
//   ext_o    selected byte/halfword, sign- or zero-extended (whole word for W)
//   merge_o  rdata_i with the addressed lane replaced by store data
// -----------------------------------------------------------------------------
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] wd_i,
  output logic [31:0] ext_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    // Halfwords are aligned, so only off_i[1] picks the half.
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Load extraction.
  always_comb begin
    ext_o = rdata_i;
    case (size_i)
      LDST_B:  ext_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: ext_o = {24'h0, byte_sel};
      LDST_H:  ext_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: ext_o = {16'h0, half_sel};
      default: ext_o = rdata_i;
    endcase
  end

  // Store merge: keep the memory word and overwrite only the addressed lane.
  always_comb begin
    merge_o = rdata_i;
    case (size_i)
      LDST_B: begin
        case (off_i)
          2'd0: merge_o[7:0]   = wd_i[7:0];
          2'd1: merge_o[15:8]  = wd_i[7:0];
          2'd2: merge_o[23:16] = wd_i[7:0];
          2'd3: merge_o[31:24] = wd_i[7:0];
          default: merge_o = rdata_i;
        endcase
      end
      LDST_H: begin
        if (off_i[1]) merge_o[31:16] = wd_i[15:0];
        else          merge_o[15:0]  = wd_i[15:0];
      end
      default: merge_o = wd_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu
// RV32I load/store unit driving a word-wide data memory with one-cycle
// synchronous read latency and no byte enables.
//   Core side : core_req_i/core_we_i/core_size_i/core_addr_i/core_wd_i in,
//               core_rd_o (extended load data), core_stall_o, core_err_o out.
//   Memory    : mem_req_o/mem_we_o/mem_addr_o/mem_wd_o out, mem_rd_i in.
// Loads take two cycles (request, response). Word stores take one cycle.
// Byte/halfword stores read the word, then write it back with the lane
// replaced (read-modify-write), stalling the core during the read cycle.
// Illegal requests (bad size, misalignment, unsigned store) pulse core_err_o
// and never reach memory.
// -----------------------------------------------------------------------------
module riscv_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  // The response timing below assumes read data arrives exactly one cycle
  // after the request.
  if (MEM_LATENCY != 1) begin : g_latency_check
    $error("riscv_lsu: only MEM_LATENCY=1 is supported");
  end

  lsu_state_t  state_q, state_d;
  logic [1:0]  off_q,   off_d;
  logic [2:0]  size_q,  size_d;
  logic [31:0] wd_q,    wd_d;
  logic [31:0] addr_q,  addr_d;

  logic        req_ok;
  logic [31:0] lane_ext;
  logic [31:0] lane_merge;

  // One lane unit serves both paths: LOAD_RESP uses the extraction, RMW_WRITE
  // uses the merge, and both work from the latched offset/size.
  lsu_byte_lane u_byte_lane (
    .rdata_i (mem_rd_i),
    .off_i   (off_q),
    .size_i  (size_q),
    .wd_i    (wd_q),
    .ext_o   (lane_ext),
    .merge_o (lane_merge)
  );

  assign req_ok = req_legal(core_we_i, core_size_i, core_addr_i[1:0]);

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    wd_d         = wd_q;
    addr_d       = addr_q;
    core_rd_o    = '0;
    core_stall_o = 1'b0;
    core_err_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wd_o     = '0;

    // While reset is asserted every output stays at zero, even if the core
    // keeps presenting a request.
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          if (core_req_i) begin
            if (!req_ok) begin
              core_err_o = 1'b1;
            end else begin
              mem_req_o  = 1'b1;
              mem_addr_o = word_addr(core_addr_i);
              if (core_we_i && (core_size_i == LDST_W)) begin
                // Full-word store needs no read; commit in this cycle.
                mem_we_o = 1'b1;
                mem_wd_o = core_wd_i;
              end else begin
                // Load, or the read half of a sub-word store.
                core_stall_o = 1'b1;
                off_d        = core_addr_i[1:0];
                size_d       = core_size_i;
                addr_d       = word_addr(core_addr_i);
                if (core_we_i) begin
                  wd_d    = core_wd_i;
                  state_d = RMW_WRITE;
                end else begin
                  state_d = LOAD_RESP;
                end
              end
            end
          end
        end

        LOAD_RESP: begin
          core_rd_o = lane_ext;
          state_d   = IDLE;
        end

        RMW_WRITE: begin
          // Address comes from the latched copy so the write goes to the
          // word that was read even if the core has moved on.
          mem_req_o  = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = addr_q;
          mem_wd_o   = lane_merge;
          state_d    = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and request latches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      wd_q    <= '0;
      addr_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge value, independent of statement order.
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// -----------------------------------------------------------------------------
// tb_riscv_lsu
// Directed bench for riscv_lsu with a small word-wide, one-cycle-latency data
// memory model. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_riscv_lsu;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  logic        preload;
  logic [31:0] mem [0:127];

  int n_cmp = 0;
  int n_err = 0;

  riscv_lsu #(.MEM_LATENCY(1)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .core_err_o   (core_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  // Data memory: synchronous read, whole-word write.
  always @(posedge clk_i) begin
    if (preload) begin
      mem[64] <= 32'h8899AABB;  // 0x100
      mem[66] <= 32'hDEADBEEF;  // 0x108
      mem[67] <= 32'hFA111EAF;  // 0x10C
    end else if (mem_req_o) begin
      if (mem_we_o) mem[mem_addr_o[8:2]] <= mem_wd_o;
      else          mem_rd_i <= mem[mem_addr_o[8:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Control bundle {mem_req, mem_we, stall, err}.
  function automatic logic [31:0] ctrl();
    return {28'h0, mem_req_o, mem_we_o, core_stall_o, core_err_o};
  endfunction

  task automatic drive(input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
  endtask

  task automatic idle();
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_load(input string tag, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, size, addr, 32'h0);
    #2;
    check({tag, "_c0_ctrl"}, ctrl(), 32'h0000_000A);
    check({tag, "_c0_addr"}, mem_addr_o, {addr[31:2], 2'b00});
    @(posedge clk_i); #2;
    check({tag, "_c1_ctrl"}, ctrl(), 32'h0);
    check({tag, "_rd"}, core_rd_o, exp);
    @(posedge clk_i); #1;
    idle();
  endtask

  task automatic do_store_rmw(input string tag, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_wd);
    drive(1'b1, size, addr, wd);
    #2;
    check({tag, "_c0_ctrl"}, ctrl(), 32'h0000_000A);
    check({tag, "_c0_addr"}, mem_addr_o, {addr[31:2], 2'b00});
    @(posedge clk_i); #2;
    check({tag, "_c1_ctrl"}, ctrl(), 32'h0000_000C);
    check({tag, "_c1_addr"}, mem_addr_o, {addr[31:2], 2'b00});
    check({tag, "_c1_wd"}, mem_wd_o, exp_wd);
    @(posedge clk_i); #1;
    idle();
  endtask

  task automatic do_err(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr);
    drive(we, size, addr, 32'h1111_2222);
    #2;
    check({tag, "_err_ctrl"}, ctrl(), 32'h0000_0001);
    @(posedge clk_i); #1;
    idle();
    #1;
    check({tag, "_after_ctrl"}, ctrl(), 32'h0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_ni  = 1'b0;
    preload = 1'b1;
    idle();
    #3;
    // Reset values, including with a request presented during reset.
    check("rst_ctrl", ctrl(), 32'h0);
    check("rst_rd", core_rd_o, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wd", mem_wd_o, 32'h0);
    drive(1'b0, SZ_W, 32'h100, 32'h0);
    #1;
    check("rst_req_ctrl", ctrl(), 32'h0);
    check("rst_req_addr", mem_addr_o, 32'h0);
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    preload = 1'b0;
    rst_ni  = 1'b1;
    #1;
    check("idle_noreq_ctrl", ctrl(), 32'h0);
    check("idle_noreq_addr", mem_addr_o, 32'h0);
    @(posedge clk_i); #1;

    // Loads from 0x100 = 0x8899AABB.
    do_load("lb_101",  SZ_B,  32'h101, 32'hFFFF_FFAA);
    do_load("lhu_102", SZ_HU, 32'h102, 32'h0000_8899);
    do_load("lh_102",  SZ_H,  32'h102, 32'hFFFF_8899);
    do_load("lw_100",  SZ_W,  32'h100, 32'h8899_AABB);
    do_load("lbu_100", SZ_BU, 32'h100, 32'h0000_00BB);
    do_load("lb_103",  SZ_B,  32'h103, 32'hFFFF_FF88);

    // Byte RMW store into the top lane.
    do_store_rmw("sb_103", SZ_B, 32'h103, 32'h1234_5677, 32'h7799_AABB);
    do_load("lw_100_sb", SZ_W, 32'h100, 32'h7799_AABB);

    // Single-cycle word store, then back-to-back loads.
    drive(1'b1, SZ_W, 32'h104, 32'hCAFE_F00D);
    #2;
    check("sw_104_ctrl", ctrl(), 32'h0000_000C);
    check("sw_104_addr", mem_addr_o, 32'h104);
    check("sw_104_wd", mem_wd_o, 32'hCAFE_F00D);
    @(posedge clk_i); #1;
    idle();
    do_load("lw_104",  SZ_W, 32'h104, 32'hCAFE_F00D);
    do_load("lb_104",  SZ_B, 32'h104, 32'h0000_000D);
    do_load("lh_106",  SZ_H, 32'h106, 32'hFFFF_CAFE);

    // Illegal requests.
    do_err("lh_101",  1'b0, SZ_H,  32'h101);
    do_err("sz3_100", 1'b0, 3'd3,  32'h100);
    do_err("shu_100", 1'b1, SZ_HU, 32'h100);
    do_err("lw_102",  1'b0, SZ_W,  32'h102);
    do_err("sbu_100", 1'b1, SZ_BU, 32'h100);
    do_load("lw_100_err", SZ_W, 32'h100, 32'h7799_AABB);

    // Sentinel data passes through; RMW merges with it.
    do_load("lw_108",  SZ_W,  32'h108, 32'hDEAD_BEEF);
    do_load("lh_10a",  SZ_H,  32'h10A, 32'hFFFF_DEAD);
    do_load("lhu_10c", SZ_HU, 32'h10C, 32'h0000_1EAF);
    do_store_rmw("sh_10c", SZ_H, 32'h10C, 32'h1234_ABCD, 32'hFA11_ABCD);
    do_load("lw_10c", SZ_W, 32'h10C, 32'hFA11_ABCD);

    // Reset in the middle of a halfword RMW: no write may reach memory.
    drive(1'b1, SZ_H, 32'h102, 32'h0000_5555);
    #2;
    check("sh_102_c0_ctrl", ctrl(), 32'h0000_000A);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    idle();
    #1;
    check("midrst_ctrl", ctrl(), 32'h0);
    check("midrst_addr", mem_addr_o, 32'h0);
    check("midrst_wd", mem_wd_o, 32'h0);
    check("midrst_rd", core_rd_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    #1;
    check("postrst_ctrl", ctrl(), 32'h0);
    @(posedge clk_i); #1;
    do_load("lw_100_rst", SZ_W, 32'h100, 32'h7799_AABB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit: the initiator side of the core's data-memory interface (mem_req / write_enable / addr / write_data / read_data).
- Accepts RV32I load/store requests from the execute stage and drives the word-wide data memory. That memory has 1-cycle synchronous read latency and no byte enables.
- Performs byte-lane extraction with sign/zero extension on loads, and read-modify-write (RMW) for byte/halfword stores.
- Stalls the core while a multi-cycle access is in flight.

Parameters:
- MEM_LATENCY, 1, read latency of data memory in cycles; only 1 is supported, any other value is a static elaboration error.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  access request; held stable with all core_* inputs while core_stall_o=1
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  RV32I funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, LSB-aligned
- core_rd_o  out  32  load result, extended
- core_stall_o  out  1  hold pipeline
- core_err_o  out  1  misaligned or illegal-size request, 1-cycle pulse
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  word address {addr[31:2],2'b00}
- mem_wd_o  out  32  memory write data
- mem_rd_i  in  32  memory read data, valid 1 cycle after read request

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; latched regs off_q, size_q, wd_q = 0.
  - All outputs 0: core_rd_o, core_stall_o, core_err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wd_o.
- States: IDLE, LOAD_RESP, RMW_WRITE.
- Request check (IDLE):
  - Illegal: size in {3,6,7}; H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Illegal request: core_err_o=1 combinationally, mem_req_o=0, core_stall_o=0, state stays IDLE.
- Load (IDLE, legal request, we=0):
  - Cycle 0: mem_req_o=1, mem_we_o=0, mem_addr_o=word address, core_stall_o=1.
  - Cycle 0 edge: latch off_q=addr[1:0] and size_q; go to LOAD_RESP.
  - Cycle 1 (LOAD_RESP): mem_req_o=0; core_rd_o=extract(mem_rd_i, off_q, size_q); core_stall_o=0; go to IDLE.
  - core_rd_o=0 in every other state.
  - Load latency: 2 cycles.
- Word store (size W, we=1):
  - Cycle 0: mem_req_o=1, mem_we_o=1, mem_wd_o=core_wd_i, core_stall_o=0; state stays IDLE.
  - Single cycle; write commits at that edge.
- Sub-word store (B/H, we=1):
  - Cycle 0: read of the word (mem_req_o=1, mem_we_o=0), core_stall_o=1; latch off_q, size_q, wd_q; go to RMW_WRITE.
  - Cycle 1 (RMW_WRITE): mem_req_o=1, mem_we_o=1, mem_addr_o unchanged, core_stall_o=0; go to IDLE.
  - mem_wd_o = mem_rd_i with the selected lane replaced by wd_q[7:0] (B) or wd_q[15:0] (H).
  - BU/HU with we=1 are illegal (core_err_o).
- Extract rules:
  - B: sign-extend byte off_q. BU: zero-extend byte off_q.
  - H: sign-extend halfword off_q[1]. HU: zero-extend halfword off_q[1].
  - W: whole word.
- Sentinel data (0xdeadbeef / 0xfa111eaf) from memory passes through unmodified. The RMW merge uses whatever the memory returns.
- core_req_i=0 in IDLE: all memory outputs 0, no state change.
- Back-to-back: a new request is accepted in the cycle after core_stall_o falls; no bubble is required.
- Reset mid-operation (LOAD_RESP or RMW_WRITE): return to IDLE immediately; no write is issued.

Decomposition:
- lsu_pkg:
  - size constants LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5
  - lsu_state_t enum {IDLE, LOAD_RESP, RMW_WRITE}
- Sub-module lsu_byte_lane (combinational): extract and merge functions, shared by the load and RMW paths.

Test Plan:
(memory word 0x100 preloaded 0x8899AABB)
- LB 0x101 -> cycle0: mem_req_o=1, mem_we_o=0, mem_addr_o=0x100, stall=1; cycle1: core_rd_o=0xFFFFFFAA, stall=0.
- LHU 0x102 -> core_rd_o=0x00008899; LH 0x102 -> 0xFFFF8899; LW 0x100 -> 0x8899AABB.
- SB 0x103, wd=0x12345677 -> cycle0: read 0x100; cycle1: mem_we_o=1, mem_wd_o=0x7799AABB, stall=0; following LW 0x100 -> 0x7799AABB.
- SW 0x104, wd=0xCAFEF00D -> single cycle: mem_req_o=1, mem_we_o=1, mem_addr_o=0x104, stall=0; LW 0x104 -> 0xCAFEF00D.
- LH 0x101, size=3 at 0x100, and SHU 0x100 -> each gives core_err_o=1 for one cycle, mem_req_o=0, stall=0, memory unchanged.
- SH 0x102 with rst_ni pulled low during RMW_WRITE -> no write issued, all outputs 0, state IDLE; LW 0x100 -> original word.
